// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store initiator between the core MEM stage
// and a word-wide data memory. Sub-word stores are done as read-modify-write
// because the memory only has a full-word write enable.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_STORE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        accept;
  logic        req_fault;

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      2'b00:   return sgn ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      2'b01:   return sgn ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
      default: return word;
    endcase
  endfunction

  // Replace the store lanes of the old memory word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] mask;
    case (size)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

  assign req_fault = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]))
                   | (req_addr >= ADDR_LIMIT);

  assign accept    = req_valid & req_ready;
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  // Next-state, memory port and handshake decode; reset forces all outputs quiet.
  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_A     = 32'h0;
    mem_WD    = 32'h0;
    mem_WE    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wdata_d = req_wdata;
          if (req_fault) begin
            rdata_d = 32'h0;
            fault_d = 1'b1;
            state_d = S_RESP;
          end else if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_size == 2'b10) begin
            state_d = S_STORE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_LOAD: begin
        mem_A   = {addr_q[31:2], 2'b00};
        rdata_d = load_extract(mem_RD, addr_q[1:0], size_q, signed_q);
        fault_d = 1'b0;
        state_d = S_RESP;
      end
      S_READ: begin
        mem_A   = {addr_q[31:2], 2'b00};
        wdata_d = store_merge(mem_RD, wdata_q, addr_q[1:0], size_q);
        state_d = S_STORE;
      end
      S_STORE: begin
        mem_A   = {addr_q[31:2], 2'b00};
        mem_WD  = wdata_q;
        mem_WE  = 1'b1;
        rdata_d = 32'h0;
        fault_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (RST) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_A     = 32'h0;
      mem_WD    = 32'h0;
      mem_WE    = 1'b0;
    end
  end

  // Control state and response registers, synchronously reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Request fields latched on acceptance; store word carried through the RMW.
  always_ff @(posedge CLK) begin
    wdata_q <= wdata_d;
    if (accept) begin
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, request-level reference model
// checked every cycle, and directed transactions with literal expectations.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  mem_access_unit #(.ADDR_LIMIT(32'h0000_0400)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Data memory: 256 words, combinational read, write on rising edge.
  logic [31:0] mem [256];
  assign mem_RD = mem[mem_A[9:2]];

  always @(posedge CLK) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8) ? 32'h1122_3344 : 32'h0;
    end else if (mem_WE) begin
      mem[mem_A[9:2]] <= mem_WD;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: one outstanding request, described by the cycles in
  // which it uses memory, writes, and responds.
  logic [31:0] ref_mem [256];
  logic        pend = 1'b0;
  logic        p_fault, p_we;
  int          p_acc, p_due;
  logic [31:0] p_waddr, p_wd, p_rdata;
  logic [31:0] h_rdata = 32'h0;
  logic        h_fault = 1'b0;
  logic        e_ready, e_rv, e_we, m_fault;
  logic [31:0] e_a, e_wd, m_word, m_lane, m_mask, m_v;
  int          m_sh;

  always @(negedge CLK) begin
    if (cyc == 1) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = (i == 8) ? 32'h1122_3344 : 32'h0;
    end
    if (pend && cyc == p_due) begin
      h_rdata = p_rdata;
      h_fault = p_fault;
    end
    e_ready = !RST && !(pend && cyc <= p_due);
    e_rv    = pend && (cyc == p_due) && !RST;
    e_we    = pend && p_we && !p_fault && (cyc == p_due - 1) && !RST;
    e_a     = (pend && !p_fault && cyc >= p_acc && cyc < p_due && !RST) ? p_waddr : 32'h0;
    e_wd    = e_we ? p_wd : 32'h0;
    chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
    chk("rsp_rdata", rsp_rdata, h_rdata);
    chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, h_fault});
    chk("mem_WE", {31'b0, mem_WE}, {31'b0, e_we});
    chk("mem_A", mem_A, e_a);
    chk("mem_WD", mem_WD, e_wd);
    if (e_we) ref_mem[p_waddr[9:2]] = p_wd;
    if (RST) begin
      pend    = 1'b0;
      h_rdata = 32'h0;
      h_fault = 1'b0;
    end else if (req_valid && e_ready) begin
      m_fault = (req_size == 2'b11) || (req_size == 2'b01 && req_addr % 2 != 0)
             || (req_size == 2'b10 && req_addr % 4 != 0) || (req_addr >= 32'h400);
      pend    = 1'b1;
      p_fault = m_fault;
      p_we    = req_we;
      p_acc   = cyc + 1;
      p_due   = cyc + (m_fault ? 1 : ((!req_we || req_size == 2'b10) ? 2 : 3));
      p_waddr = req_addr - (req_addr % 4);
      m_sh    = 8 * int'(req_addr % 4);
      m_word  = ref_mem[req_addr[9:2]];
      m_lane  = m_word >> m_sh;
      if (req_size == 2'b00) begin
        m_v = m_lane & 32'hFF;
        if (req_signed && m_v >= 32'h80) m_v = m_v | 32'hFFFF_FF00;
        m_mask = 32'hFF;
      end else if (req_size == 2'b01) begin
        m_v = m_lane & 32'hFFFF;
        if (req_signed && m_v >= 32'h8000) m_v = m_v | 32'hFFFF_0000;
        m_mask = 32'hFFFF;
      end else begin
        m_v = m_word;
        m_mask = 32'hFFFF_FFFF;
      end
      m_mask  = m_mask << m_sh;
      p_rdata = (m_fault || req_we) ? 32'h0 : m_v;
      p_wd    = (m_word & ~m_mask) | ((req_wdata << m_sh) & m_mask);
    end
  end

  // Issue one request starting just after a rising edge with the unit idle;
  // returns the response and the number of cycles from acceptance to rsp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat);
    int k;
    bit got;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!req_ready && k < 20);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    lat = 0; got = 0; rd = 32'hx; flt = 1'bx;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        got = 1; lat = i; rd = rsp_rdata; flt = rsp_fault;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic req_chk(input string nm, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
    logic [31:0] rd;
    logic        flt;
    int          lat;
    do_req(we, sz, sg, a, wd, rd, flt, lat);
    chk({nm, ".rdata"}, rd, exp_rd);
    chk({nm, ".fault"}, {31'b0, flt}, {31'b0, exp_flt});
    chk({nm, ".latency"}, lat, exp_lat);
  endtask

  int          n_rsp, acc2, rcyc[4];
  logic [31:0] rdat[4];

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.rsp_fault", {31'b0, rsp_fault}, 32'h0);
    @(posedge CLK);
    #1;

    // Word path
    req_chk("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    chk("sw.mem", mem[4], 32'hDEAD_BEEF);
    req_chk("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    // Byte read-modify-write (upper store-data bits must be ignored)
    req_chk("sb", 1'b1, 2'b00, 1'b0, 32'h21, 32'h7777_77AA, 32'h0, 1'b0, 3);
    chk("sb.mem", mem[8], 32'h1122_AA44);
    req_chk("lb", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
    req_chk("lbu", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_00AA, 1'b0, 2);
    req_chk("lbu3", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h0000_0011, 1'b0, 2);

    // Halfword
    req_chk("sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h5555_8001, 32'h0, 1'b0, 3);
    chk("sh.mem", mem[8], 32'h8001_AA44);
    req_chk("lh", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    req_chk("lhu", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h0000_AA44, 1'b0, 2);

    // Faults
    req_chk("f_lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
    req_chk("f_sh31", 1'b1, 2'b01, 1'b0, 32'h31, 32'h1234, 32'h0, 1'b1, 1);
    req_chk("f_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    req_chk("f_lw400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
    req_chk("f_sw400", 1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    chk("fault.mem20", mem[8], 32'h8001_AA44);
    chk("fault.mem30", mem[12], 32'h0);
    req_chk("lw3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0, 2);

    // Reset during the STORE cycle of a byte store
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rststore.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rststore.mem", mem[8], 32'h8001_AA44);
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) n_rsp++;
      @(negedge CLK);
    end
    chk("rststore.no_rsp", n_rsp, 0);
    @(posedge CLK);
    #1;

    // Busy hold: valid stays high, address changes while the first load runs
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_addr = 32'h10;
    n_rsp = 0; acc2 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (rsp_valid && n_rsp < 4) begin
        rcyc[n_rsp] = cyc; rdat[n_rsp] = rsp_rdata; n_rsp++;
      end
      if (req_ready && req_valid && acc2 < 0) acc2 = cyc;
      @(posedge CLK);
      #1;
      if (acc2 >= 0) req_valid = 1'b0;
    end
    chk("busy.count", n_rsp, 2);
    chk("busy.first", rdat[0], 32'h8001_AA44);
    chk("busy.second", rdat[1], 32'hDEAD_BEEF);
    chk("busy.accept2", acc2, rcyc[0] + 1);
    chk("busy.spacing", rcyc[1] - rcyc[0], 3);

    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store initiator sitting between the MIPS core's MEM stage and the word-wide data memory. Accepts byte, halfword and word loads and stores addressed in bytes, converts them to word accesses on the memory port, and does read-modify-write for sub-word stores because the memory has only a full-word write enable. Sign/zero-extends load data, detects misaligned or out-of-range accesses, and returns a one-cycle response to the core.

## Interface

Parameters:
- ADDR_LIMIT, 32'h0000_0400, first illegal byte address; size of the data memory in bytes (256 words).

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  unit idle, request accepted this cycle if req_valid
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load result; 0 for stores and faults
- rsp_fault  out  1  request rejected, qualified by rsp_valid
- mem_A  out  32  byte address to data memory, always word-aligned
- mem_WD  out  32  write data to data memory
- mem_WE  out  1  write enable to data memory
- mem_RD  in  32  read data; combinational from mem_A, valid same cycle

## Operation

- Little-endian lanes: byte offset k occupies bits [8k+7:8k]; halfword offset 0 -> [15:0], 2 -> [31:16].
- Request accepted at the edge where req_valid & req_ready; addr, size, we, signed, wdata latched. req_valid while busy is ignored.
- Fault if any: req_size = 11; half with addr[0] = 1; word with addr[1:0] != 0; addr >= ADDR_LIMIT. Fault requests never touch memory.
- States:
  - IDLE: req_ready = 1. Accept -> RESP (fault), LOAD (load), STORE (word store), READ (byte/half store).
  - LOAD: mem_A = {addr[31:2],2'b00}; mem_RD lane-selected, extended, registered into rsp_rdata -> RESP.
  - READ: mem_A driven; mem_RD captured, store lanes replaced with wdata -> STORE.
  - STORE: mem_A driven, mem_WD = merged word (word store: wdata), mem_WE = 1 -> RESP.
  - RESP: rsp_valid = 1 for this cycle only -> IDLE.
- mem_WE = (state == STORE) & ~RST; high exactly one cycle per non-faulting store.
- Outside LOAD/READ/STORE: mem_A = 0, mem_WD = 0, mem_WE = 0.
- rsp_rdata and rsp_fault registered, hold last value between responses.

## Timing

- Reset values: req_ready 0 while RST high, 1 in first cycle after; rsp_valid 0, rsp_rdata 0, rsp_fault 0, mem_A 0, mem_WD 0, mem_WE 0; state IDLE.
- Cycles from acceptance edge to rsp_valid high: fault 1, load 2, word store 2, byte/half store 3.
- req_ready low from cycle after acceptance through RESP; next request earliest accepted in the cycle after RESP (back-to-back throughput: load every 3 cycles).
- RST high in any cycle: next state IDLE, no rsp_valid for the aborted request. RST high during STORE suppresses the write (memory unchanged).
- Memory write takes effect at the edge ending STORE; a load accepted after RESP observes it.

## Test plan

- Word path: sw 0xDEADBEEF @0x10, then lw @0x10 -> mem_WE high exactly 1 cycle with mem_A 0x10, mem_WD 0xDEADBEEF; rsp_valid 2 cycles after each accept; rsp_rdata 0xDEADBEEF, rsp_fault 0.
- Byte RMW: word @0x20 = 0x11223344; sb 0xAA @0x21 -> memory 0x1122AA44, rsp_valid 3 cycles after accept; lb @0x21 -> 0xFFFFFFAA; lbu @0x21 -> 0x000000AA.
- Halfword: sh 0x8001 @0x22 -> memory 0x8001AA44; lh @0x22 -> 0xFFFF8001; lhu @0x20 -> 0x0000AA44.
- Faults: lw @0x13, sh @0x31, size 11 @0x0, lw @0x400 -> each rsp_valid 1 cycle after accept with rsp_fault 1, rsp_rdata 0, mem_WE never high, memory unchanged.
- Reset mid-store: sb 0x55 @0x20, RST high during STORE cycle -> memory stays 0x8001AA44, no rsp_valid, req_ready 1 the cycle after RST drops.
- Busy hold: req_valid held high across two requests -> second accepted only in the cycle after first RESP; changes to req_addr while busy have no effect on the first access.
